// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register dump engine.
// REG_DUMP_CHECKSUM_EN adds the CSUM state (trailing XOR checksum word).
package reg_dump_pkg;

    localparam int          REG_COUNT  = 32;
    localparam logic [5:0]  CSUM_INDEX = 6'd32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SEND,
`ifdef REG_DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

endpackage

// File: rtl/reg_dump_engine_if.sv
// Register-file read port plus the valid/ready output word stream.
interface reg_dump_engine_if;

    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_index;
    logic        out_last;

    modport master (
        output rd_addr,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_index,
        output out_last
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_index,
        input  out_last
    );

endinterface

// File: rtl/reg_dump_out_stage.sv
// Output holding register: loads one word, holds it until the sink takes it.
module reg_dump_out_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] ld_data,
    input  logic [5:0]  ld_index,
    input  logic        ld_last,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [5:0]  out_index,
    output logic        out_last
);

    logic        vld_p0;
    logic [31:0] data_p0;
    logic [5:0]  index_p0;
    logic        last_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0   <= 1'b0;
            data_p0  <= '0;
            index_p0 <= '0;
            last_p0  <= 1'b0;
        end else if (load) begin
            vld_p0   <= 1'b1;
            data_p0  <= ld_data;
            index_p0 <= ld_index;
            last_p0  <= ld_last;
        end else if (vld_p0 && out_ready) begin
            vld_p0   <= 1'b0;
        end
    end

    assign out_valid = vld_p0;
    assign out_data  = data_p0;
    assign out_index = index_p0;
    assign out_last  = last_p0;

endmodule

// File: rtl/reg_dump_engine.sv
// Walks register indices FIRST_REG..LAST_REG, streaming each value out.
// REG_DUMP_CHECKSUM_EN appends an XOR checksum word (index 32) as the last word.
module reg_dump_engine
    import reg_dump_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    reg_dump_engine_if.master  bus
);

    localparam int AW = $clog2(REG_COUNT);
    localparam int IW = $bits(CSUM_INDEX);

    state_t                state, state_nx;
    logic [AW-1:0]         rd_addr_q;
    logic                  addr_load, addr_inc;
    logic                  ld, ld_last, hs;
    logic [31:0]           ld_data;
    logic [IW-1:0]         ld_index;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [31:0]           csum;
    logic                  csum_clr, csum_acc;
`endif

    assign hs = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        addr_load = 1'b0;
        addr_inc  = 1'b0;
        ld        = 1'b0;
        ld_data   = bus.rd_data;
        ld_index  = IW'(rd_addr_q);
        ld_last   = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_clr  = 1'b0;
        csum_acc  = 1'b0;
`endif
        case (state)
            S_IDLE: if (start) begin
                addr_load = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                csum_clr  = 1'b1;
`endif
                state_nx  = S_ISSUE;
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                ld       = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                csum_acc = 1'b1;
`else
                ld_last  = (rd_addr_q == AW'(LAST_REG));
`endif
                state_nx = S_SEND;
            end
            S_SEND: if (hs) begin
                if (bus.out_index < IW'(LAST_REG)) begin
                    addr_inc = 1'b1;
                    state_nx = S_ISSUE;
                end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                    state_nx = S_CSUM;
`else
                    state_nx = S_DONE;
`endif
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            // First CSUM cycle sees valid low (post-handshake) and loads the checksum word.
            S_CSUM: begin
                if (!bus.out_valid) begin
                    ld       = 1'b1;
                    ld_data  = csum;
                    ld_index = CSUM_INDEX;
                    ld_last  = 1'b1;
                end else if (hs) begin
                    state_nx = S_DONE;
                end
            end
`endif
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rd_addr_q <= '0;
        else if (addr_load) rd_addr_q <= AW'(FIRST_REG);
        else if (addr_inc)  rd_addr_q <= rd_addr_q + AW'(1);
    end

`ifdef REG_DUMP_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        csum <= '0;
        else if (csum_clr) csum <= '0;
        else if (csum_acc) csum <= csum ^ bus.rd_data;
    end
`endif

    reg_dump_out_stage u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld),
        .ld_data   (ld_data),
        .ld_index  (ld_index),
        .ld_last   (ld_last),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_index (bus.out_index),
        .out_last  (bus.out_last)
    );

    assign bus.rd_addr = rd_addr_q;
    assign busy        = (state != S_IDLE) && (state != S_DONE);
    assign done        = (state == S_DONE);

endmodule

// File: tb/tb_reg_dump_engine.sv
// Directed + randomized bench for reg_dump_engine with a queue-based word model.
module tb_reg_dump_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic rdy = 1'b1;
    logic busy_a, done_a, busy_b, done_b;
    logic [31:0] regs [32];
    int sel = 0;
    int n_tests = 0;
    int n_fail = 0;

    reg_dump_engine_if bus_a ();
    reg_dump_engine_if bus_b ();

    reg_dump_engine dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .bus(bus_a)
    );

    reg_dump_engine #(.FIRST_REG(4), .LAST_REG(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b)
    );

    always #5 clk = ~clk;

    assign bus_a.out_ready = rdy;
    assign bus_b.out_ready = rdy;

    // Register file: one-cycle synchronous read
    always @(posedge clk) begin
        bus_a.rd_data <= regs[bus_a.rd_addr];
        bus_b.rd_data <= regs[bus_b.rd_addr];
    end

    wire        m_valid = (sel != 0) ? bus_b.out_valid : bus_a.out_valid;
    wire [31:0] m_data  = (sel != 0) ? bus_b.out_data  : bus_a.out_data;
    wire [5:0]  m_index = (sel != 0) ? bus_b.out_index : bus_a.out_index;
    wire        m_last  = (sel != 0) ? bus_b.out_last  : bus_a.out_last;
    wire        m_busy  = (sel != 0) ? busy_b : busy_a;
    wire        m_done  = (sel != 0) ? done_b : done_a;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam int LAT_FULL = 0;
    localparam int LAT_B    = 0;
`else
    localparam int LAT_FULL = 97;
    localparam int LAT_B    = 10;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input int s, input logic v);
        if (s != 0) start_b = v;
        else        start_a = v;
    endtask

    // mode 0: ready high, 1: random ready, 2: 5-cycle stall on word 7
    task automatic run_dump(input int s, input int first, input int last, input int mode,
                            input int exp_cycles, input bit restart);
        logic [38:0] q[$];
        logic [38:0] w, prev;
        logic [31:0] x;
        bit hold, hs_prev, seen_done;
        int cyc, stall;
        x = '0; hold = 0; hs_prev = 0; seen_done = 0; stall = 0; prev = '0;
        for (int i = first; i <= last; i++) begin
`ifdef REG_DUMP_CHECKSUM_EN
            q.push_back({1'b0, 6'(i), regs[i]});
`else
            q.push_back({(i == last), 6'(i), regs[i]});
`endif
            x ^= regs[i];
        end
`ifdef REG_DUMP_CHECKSUM_EN
        q.push_back({1'b1, 6'd32, x});
`endif
        sel = s;
        @(negedge clk);
        drive_start(s, 1'b1);
        @(negedge clk);
        drive_start(s, 1'b0);
        cyc = 1;
        check("busy_after_start", m_busy, 1);
        while (cyc < 3000) begin
            w = {m_last, m_index, m_data};
            if (hs_prev) check("valid_drop_after_hs", m_valid, 0);
            if (m_done) begin
                seen_done = 1;
                break;
            end
            if (hold) check("hold_stable", {m_valid, w}, {1'b1, prev});
            if (restart) drive_start(s, cyc == 5);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    if (m_valid && m_index == 6'd7 && stall < 5) begin
                        rdy = 1'b0;
                        stall++;
                        check("stall_word7", w[37:0], {6'd7, regs[7]});
                    end else begin
                        rdy = 1'b1;
                    end
                end
            endcase
            hs_prev = m_valid && rdy;
            if (hs_prev) begin
                if (q.size() == 0) check("extra_word_index", m_index, 6'h3f);
                else               check("word", w, q.pop_front());
            end
            hold = m_valid && !rdy;
            prev = w;
            @(negedge clk);
            cyc++;
        end
        check("done_seen", seen_done, 1);
        check("words_left", q.size(), 0);
        if (exp_cycles != 0) check("done_latency", cyc, exp_cycles);
        check("busy_at_done", m_busy, 0);
        rdy = 1'b1;
        if (restart) drive_start(s, 1'b1);
        @(negedge clk);
        drive_start(s, 1'b0);
        check("done_one_cycle", m_done, 0);
        repeat (4) @(negedge clk);
        check("idle_after_dump", {m_busy, m_valid}, 0);
    endtask

    initial begin
        bit found, bad;
        for (int i = 0; i < 32; i++) regs[i] = i * 3;

        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",      busy_a, 0);
        check("rst_done",      done_a, 0);
        check("rst_valid",     bus_a.out_valid, 0);
        check("rst_last",      bus_a.out_last, 0);
        check("rst_rd_addr",   bus_a.rd_addr, 0);
        check("rst_out_data",  bus_a.out_data, 0);
        check("rst_out_index", bus_a.out_index, 0);
        check("rst_b_valid",   bus_b.out_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_dump(0, 0, 31, 0, LAT_FULL, 0);
        run_dump(0, 0, 31, 2, 0, 0);

        for (int i = 0; i < 32; i++) regs[i] = 32'h1 << i;
        run_dump(0, 0, 31, 1, 0, 0);

        repeat (3) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            run_dump(0, 0, 31, 1, 0, 0);
        end

        run_dump(1, 4, 6, 0, LAT_B, 1);
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        run_dump(1, 4, 6, 1, 0, 1);

        // Reset while word 10 is stalled in SEND
        sel = 0;
        rdy = 1'b1;
        found = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (bus_a.out_valid && bus_a.out_index == 6'd10) begin
                rdy = 1'b0;
                found = 1;
            end else begin
                @(negedge clk);
            end
        end
        check("reach_word10", found, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", bus_a.out_valid, 0);
        check("midrst_busy",  busy_a, 0);
        check("midrst_index", bus_a.out_index, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_a || bus_a.out_valid || busy_a) bad = 1;
        end
        check("no_done_after_rst", bad, 0);
        run_dump(0, 0, 31, 0, LAT_FULL, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_dump_engine.md
REG_DUMP_ENGINE -- requirements
Module: reg_dump_engine

Interface
REQ-001 SHALL have parameter FIRST_REG, default 0, meaning the first register index dumped.
REQ-002 SHALL have parameter LAST_REG, default 31, meaning the last register index dumped (FIRST_REG <= LAST_REG <= 31).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle dump request, sampled only in IDLE.
REQ-006 busy  output  1  high from the cycle after accepted start until done.
REQ-007 done  output  1  one-cycle pulse when the dump completes.
REQ-008 rd_addr  output  5  register-file read address, driven from a flop.
REQ-009 rd_data  input  32  register-file read data; one-cycle synchronous read of the rd_addr present at the previous rising edge.
REQ-010 out_valid  output  1  out_data/out_index/out_last valid.
REQ-011 out_ready  input  1  sink accepts the word when high with out_valid.
REQ-012 out_data  output  32  dumped register value.
REQ-013 out_index  output  6  register number of out_data (32 = checksum word).
REQ-014 out_last  output  1  high with the final word of the dump.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, SEND, CSUM and DONE.
REQ-016 IDLE: on start=1 load rd_addr=FIRST_REG, clear checksum, go to ISSUE; otherwise stay.
REQ-017 ISSUE: hold rd_addr for one cycle, go to WAIT.
REQ-018 WAIT: capture rd_data into out_data, rd_addr into out_index, XOR rd_data into checksum, assert out_valid, go to SEND.
REQ-019 SEND: hold all out_* stable while out_valid=1 and out_ready=0.
REQ-020 SEND with handshake: if out_index<LAST_REG, increment rd_addr and go to ISSUE; else go to CSUM (macro defined) or DONE.
REQ-021 out_valid SHALL deassert the cycle after a handshake.
REQ-022 Minimum cost SHALL be 3 cycles per word with out_ready tied high; there SHALL be no bubbles beyond those 3.
REQ-023 out_last SHALL be high only on the final word: LAST_REG without checksum, the checksum word with it.
REQ-024 DONE: pulse done=1 and busy=0 for one cycle, then return to IDLE.
REQ-025 start SHALL be ignored while busy=1 and in DONE.
REQ-026 The block SHALL never write the register file; writes landing mid-dump are captured only if issued before the affected ISSUE cycle (no snapshot guarantee).
REQ-027 rd_addr arithmetic SHALL be 5-bit; LAST_REG=31 SHALL terminate without wrap to 0.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE with busy=0, done=0, out_valid=0, out_last=0, rd_addr=0, out_data=0, out_index=0 and checksum=0.
REQ-029 Reset mid-dump SHALL abandon the dump with no done pulse; out_valid drops immediately.

Configuration
REQ-030 Macro REG_DUMP_CHECKSUM_EN defined: after LAST_REG, CSUM state presents out_data=XOR of all dumped words, out_index=32, out_last=1, held until handshake, then DONE.
REQ-031 REG_DUMP_CHECKSUM_EN undefined: no CSUM state, no checksum register; out_last accompanies LAST_REG.

Structure
REQ-032 Package reg_dump_pkg SHALL hold the state enum, REG_COUNT=32 and CSUM_INDEX=6'd32.
REQ-033 The output holding register with valid/ready hold logic SHALL be a sub-module named reg_dump_out_stage.

Verification
REQ-034 Defaults, regs[n]=n*3, out_ready=1, start pulse: 32 words, index 0..31, data 0,3..93, out_last on 31, done 97 cycles after start.
REQ-035 out_ready low 5 cycles on word 7: out_data/out_index stay at 21/7 for all 5 cycles; no word lost or duplicated.
REQ-036 With REG_DUMP_CHECKSUM_EN and regs[n]=32'h1<<n: 33rd word index 32 data 32'hFFFFFFFF, out_last=1.
REQ-037 FIRST_REG=4, LAST_REG=6: exactly 3 words, indices 4,5,6; second start during busy ignored.
REQ-038 rst_n low during word 10 SEND: out_valid=0 same cycle, no done; a new start gives a full dump from FIRST_REG.
